// File: rtl/zclock_gen.sv
// Z80 clock generator: divides clk by 2^(speed+1), freezes on stall requests and
// switches speed only on a falling Z80 clock edge that lands in a refresh cycle.
module zclock_gen #(
  parameter int SPD_W       = 2,
  parameter int RESET_SPEED = 2,
  parameter int DOS_WAIT    = 4,
  parameter int IO_WAIT     = 8,
  parameter int IO_SLOW     = 1,
  parameter int WAIT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SPD_W-1:0] speed_req,
  input  logic             rfsh,
  input  logic             iorq_s,
  input  logic             external_port,
  input  logic             cpu_stall,
  input  logic             ide_stall,
  input  logic             dos_on,
  input  logic             vdos_off,
  output logic             zclk_out,
  output logic             zpos,
  output logic             zneg,
  output logic [SPD_W-1:0] speed_cur,
  output logic             stalled
);

  localparam int DIV_W = (1 << SPD_W) - 1;
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [SPD_W-1:0]  speed_cur_q, speed_cur_d;
  logic              zclk_q, zclk_d;
  logic              zpos_q, zpos_d;
  logic              zneg_q, zneg_d;
  logic              stalled_q, stalled_d;

  logic              dos_trig;
  logic              io_trig;
  logic              stall;
  logic              edge_ev;
  logic [DIV_W-1:0]  div_max;

  always_comb begin
    dos_trig    = dos_on | vdos_off;
    io_trig     = iorq_s & external_port & (int'(speed_cur_q) < IO_SLOW);
    stall       = cpu_stall | ide_stall | dos_trig | io_trig | (wait_cnt_q != '0);
    // 2^speed - 1, wrapping naturally to all-ones for the slowest code
    div_max     = (DIV_ONE << speed_cur_q) - DIV_ONE;
    edge_ev     = !stall && (div_cnt_q == div_max);

    wait_cnt_d  = wait_cnt_q;
    div_cnt_d   = div_cnt_q;
    speed_cur_d = speed_cur_q;
    zclk_d      = zclk_q;
    zpos_d      = 1'b0;
    zneg_d      = 1'b0;
    stalled_d   = stall;

    if (dos_trig) begin
      wait_cnt_d = WAIT_W'(DOS_WAIT);
    end else if (io_trig) begin
      wait_cnt_d = WAIT_W'(IO_WAIT);
    end else if (wait_cnt_q != '0) begin
      wait_cnt_d = wait_cnt_q - WAIT_ONE;
    end

    if (edge_ev) begin
      div_cnt_d = '0;
      zclk_d    = ~zclk_q;
      zpos_d    = ~zclk_q;
      zneg_d    = zclk_q;
      // Speed switches on a falling edge inside refresh, so the new rate
      // begins cleanly with the following low phase.
      if (zclk_q && rfsh && (speed_req != speed_cur_q)) begin
        speed_cur_d = speed_req;
      end
    end else if (!stall) begin
      div_cnt_d = div_cnt_q + DIV_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      speed_cur_q <= SPD_W'(RESET_SPEED);
      zclk_q      <= 1'b0;
      zpos_q      <= 1'b0;
      zneg_q      <= 1'b0;
      stalled_q   <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      speed_cur_q <= speed_cur_d;
      zclk_q      <= zclk_d;
      zpos_q      <= zpos_d;
      zneg_q      <= zneg_d;
      stalled_q   <= stalled_d;
    end
  end

  assign zclk_out  = zclk_q;
  assign zpos      = zpos_q;
  assign zneg      = zneg_q;
  assign speed_cur = speed_cur_q;
  assign stalled   = stalled_q;

endmodule

// File: doc/zclock_gen.md
ZCLOCK_GEN -- requirements
Module: zclock_gen

Interface
- REQ-001 SHALL have parameter SPD_W, default 2: width of the speed code. Speed code s gives a half-period of 2^s clk cycles; with 28 MHz clk, 0=14, 1=7, 2=3.5, 3=1.75 MHz.
- REQ-002 SHALL have parameter RESET_SPEED, default 2: value of speed_cur after reset.
- REQ-003 SHALL have parameter DOS_WAIT, default 4: extra stall cycles after a DOS trigger.
- REQ-004 SHALL have parameter IO_WAIT, default 8: extra stall cycles after an external-IO trigger.
- REQ-005 SHALL have parameter IO_SLOW, default 1: external-IO stall applies only when speed_cur < IO_SLOW.
- REQ-006 SHALL have parameter WAIT_W, default 4: wait counter width, >= clog2(max(DOS_WAIT,IO_WAIT)+1).
- REQ-007 clk  in  1  system clock (28 MHz); all logic on its rising edge.
- REQ-008 rst_n  in  1  reset, synchronous, active-low.
- REQ-009 speed_req  in  SPD_W  requested speed code.
- REQ-010 rfsh  in  1  high during a Z80 refresh cycle.
- REQ-011 iorq_s  in  1  IO request strobe, one cycle.
- REQ-012 external_port  in  1  current IO address decodes to an external port.
- REQ-013 cpu_stall  in  1  level stall from the memory arbiter.
- REQ-014 ide_stall  in  1  level stall from IDE.
- REQ-015 dos_on  in  1  DOS-entry trigger pulse.
- REQ-016 vdos_off  in  1  virtual-DOS-exit trigger pulse.
- REQ-017 zclk_out  out  1  Z80 clock level.
- REQ-018 zpos  out  1  one-cycle pulse in the cycle zclk_out rises.
- REQ-019 zneg  out  1  one-cycle pulse in the cycle zclk_out falls.
- REQ-020 speed_cur  out  SPD_W  speed code currently in effect.
- REQ-021 stalled  out  1  registered copy of the internal stall term.

Function
- REQ-022 Define the internal stall term as: cpu_stall | ide_stall | dos_trig | io_trig | (wait_cnt != 0).
  - dos_trig = dos_on | vdos_off.
  - io_trig = iorq_s & external_port & (speed_cur < IO_SLOW).
- REQ-023 wait_cnt update, in priority order:
  - dos_trig: load DOS_WAIT.
  - else io_trig: load IO_WAIT.
  - else nonzero: decrement.
  - Result: stall lasts the trigger cycle plus WAIT cycles.
- REQ-024 A trigger while wait_cnt is nonzero SHALL reload it; no accumulation.
- REQ-025 Half-period counter div_cnt, width 2^SPD_W-1 bits:
  - increments each unstalled cycle and holds while stalled.
  - An edge event occurs when div_cnt == 2^speed_cur - 1 and the cycle is unstalled; div_cnt then returns to 0.
- REQ-026 On each edge event, at the next clk edge:
  - zclk_out SHALL toggle.
  - zpos SHALL assert for one cycle if zclk_out was 0; zneg SHALL assert for one cycle if zclk_out was 1.
  - zpos and zneg are never high together.
- REQ-027 While stalled, zclk_out, div_cnt and speed_cur SHALL hold, and zpos and zneg SHALL stay 0.
- REQ-028 A speed change is pending while speed_req != speed_cur.
  - It SHALL be applied only at an edge event that produces zneg while rfsh=1.
  - At that edge: speed_cur <= speed_req and div_cnt <= 0.
  - The new half-period starts with the following low phase.
- REQ-029 Changing speed_req while a change is pending SHALL apply only the value present at the qualifying edge; returning speed_req to speed_cur cancels the change.
- REQ-030 A change request made while rfsh stays 0 SHALL never be applied.
- REQ-031 Steady state SHALL give zclk_out a 50% duty cycle: high 2^s cycles, low 2^s cycles.

Reset
- REQ-032 While rst_n=0 at a clk edge:
  - zclk_out=0, zpos=0, zneg=0, stalled=0.
  - div_cnt=0, wait_cnt=0, speed_cur=RESET_SPEED.
- REQ-033 Reset SHALL override triggers and stalls in the same cycle.
- REQ-034 Reset asserted mid-period or mid-stall SHALL abort it; the first edge event after release occurs 2^RESET_SPEED unstalled cycles later and produces zpos.

Verification
- REQ-035 Reset release, defaults, no stalls:
  - first zpos 4 cycles after release;
  - then zneg and zpos alternate every 4 cycles (period 8).
- REQ-036 speed_req=0 with rfsh=0 for 100 cycles: speed_cur stays 2. Then rfsh=1: at the next zneg speed_cur=0, and edges follow every cycle.
- REQ-037 speed_cur=0, iorq_s=1 and external_port=1 for one cycle:
  - stalled high for 9 cycles (registered, one cycle late);
  - no zpos/zneg during that window.
  - Same stimulus at speed_cur=1: no stall.
- REQ-038 dos_on and iorq_s external in the same cycle at speed 0: 5-cycle stall (DOS wins). A second dos_on 2 cycles later: stall extends to 5 cycles after it.
- REQ-039 cpu_stall held 3 cycles during a high phase at speed 2: the high phase lasts 7 cycles and duty resumes 4/4 afterwards.
- REQ-040 rst_n low for 1 cycle during an IO stall at speed 0:
  - the next cycle shows stalled=0, speed_cur=2 and zclk_out=0;
  - the first zpos comes 4 cycles after release.
